// File: rtl/adder_share_arbiter.sv
// Round-robin share of one 16-bit adder between two valid/ready requesters.
// The result lands in a single registered slot that honours downstream backpressure.

module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        overflow
);
  assign sum      = a + b;
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign overflow = (a[15] == b[15]) && (sum[15] != a[15]);
endmodule

module adder_share_arbiter #(
  parameter int WIDTH = 16  // the shared adder is fixed at 16 bits; only 16 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_overflow,
  input  logic             res_ready
);

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] sum;
    logic             ovf;
  } res_t;

  res_t             slot;
  logic             ptr;
  logic             slot_free;
  logic [1:0]       grant;
  logic             xfer;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  assign slot_free = !res_valid || res_ready;

  // Grants look only at valids and the pointer, never at the other side's operands.
  always_comb begin
    grant = 2'b00;
    if (!rst && slot_free) begin
      if (req0_valid && (!req1_valid || !ptr))
        grant = 2'b01;
      else if (req1_valid)
        grant = 2'b10;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = |grant;

  // Requester 0 is the idle default for the operand mux.
  assign op_a = grant[1] ? req1_a : req0_a;
  assign op_b = grant[1] ? req1_b : req0_b;

  adder_16bit u_add (
    .a        (op_a),
    .b        (op_b),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot      <= '0;
      res_valid <= 1'b0;
      ptr       <= 1'b0;
    end else if (xfer) begin
      slot      <= '{id: grant[1], sum: add_sum, ovf: add_ovf};
      res_valid <= 1'b1;
      // Pointer moves to whoever was not granted.
      ptr       <= grant[0];
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign res_id       = slot.id;
  assign res_sum      = slot.sum;
  assign res_overflow = slot.ovf;

endmodule
